// File: rtl/serial_alu_sequencer_pkg.sv
// Shared encodings for the bit-serial ALU sequencer.
// Op codes match the function select of the external one-bit slice.
package serial_alu_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_arith(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/serial_result_shifter.sv
// Result assembly register: bits arrive LSB-first and enter at the MSB,
// so after WIDTH shifts the word sits in its natural position.
module serial_result_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_value <= '0;
        end else if (i_shift) begin
            r_value <= {i_bit, r_value[WIDTH-1:1]};
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/serial_alu_sequencer.sv
// Sequencer that drives one external one-bit ALU slice for WIDTH cycles
// and returns a full-width result with carry/overflow/zero flags.
module serial_alu_sequencer
    import serial_alu_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_s,
    output logic             slice_carry_in,
    output logic             slice_k_in,
    output logic             slice_ans_in,
    output logic             slice_first,
    input  logic             slice_out,
    input  logic             slice_carry_out,
    input  logic             slice_k_out,
    input  logic             slice_ans_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           r_state;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_k;
    logic             r_ans;
    logic             r_cmsb;
    logic             r_start_ready;
    logic             r_result_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carryout;
    logic             r_overflow;
    logic             r_zero;

    logic             w_run;
    logic             w_accept;
    logic             w_last;
    logic             w_is_slt;
    logic [CW-1:0]    w_idx;
    logic [WIDTH-1:0] w_shift_q;
    logic [WIDTH-1:0] w_res;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = (r_state == ST_IDLE) && start_valid;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_is_slt = (r_op == ALU_SLT);
    // SLT compares from the sign bit down; everything else ripples up.
    assign w_idx    = w_is_slt ? (CW'(WIDTH - 1) - r_cnt) : r_cnt;
    assign w_res    = w_is_slt ? {{(WIDTH-1){1'b0}}, r_ans} : w_shift_q;

    assign slice_a        = w_run & r_a[w_idx];
    assign slice_b        = w_run & (r_b[w_idx] ^ (r_op == ALU_SUB));
    assign slice_s        = w_run ? 3'(r_op) : 3'd0;
    assign slice_carry_in = w_run & r_carry;
    assign slice_k_in     = w_run & r_k;
    assign slice_ans_in   = w_run & r_ans;
    assign slice_first    = w_run & w_is_slt & (r_cnt == '0);

    serial_result_shifter #(
        .WIDTH   (WIDTH)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_accept),
        .i_shift (w_run && !w_is_slt),
        .i_bit   (slice_out),
        .o_value (w_shift_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_op           <= ALU_ADD;
            r_a            <= '0;
            r_b            <= '0;
            r_cnt          <= '0;
            r_carry        <= 1'b0;
            r_k            <= 1'b0;
            r_ans          <= 1'b0;
            r_cmsb         <= 1'b0;
            r_start_ready  <= 1'b1;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_carryout     <= 1'b0;
            r_overflow     <= 1'b0;
            r_zero         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_op          <= alu_op_e'(op);
                        r_a           <= a;
                        r_b           <= b;
                        r_cnt         <= '0;
                        r_carry       <= (op == 3'(ALU_SUB));
                        r_k           <= 1'b1;
                        r_ans         <= 1'b0;
                        r_start_ready <= 1'b0;
                        r_state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_carry <= slice_carry_out;
                    r_k     <= slice_k_out;
                    r_ans   <= slice_ans_out;
                    if (w_last) begin
                        r_cmsb  <= r_carry;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the settled shift register.
                    if (!r_result_valid) begin
                        r_result       <= w_res;
                        r_carryout     <= is_arith(r_op) & r_carry;
                        r_overflow     <= is_arith(r_op) & (r_cmsb ^ r_carry);
                        r_zero         <= ~|w_res;
                        r_result_valid <= 1'b1;
                    end else if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready  = r_start_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign carryout     = r_carryout;
    assign overflow     = r_overflow;
    assign zero         = r_zero;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer: one-bit slice model plus a
// word-level arithmetic reference for results and flags.
module tb_serial_alu_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;
    logic         slice_a;
    logic         slice_b;
    logic [2:0]   slice_s;
    logic         slice_carry_in;
    logic         slice_k_in;
    logic         slice_ans_in;
    logic         slice_first;
    logic         slice_out;
    logic         slice_carry_out;
    logic         slice_k_out;
    logic         slice_ans_out;

    int errors = 0;
    int checks = 0;
    int first_cnt;
    int first_cyc;
    logic first_a;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .op              (op),
        .a               (a),
        .b               (b),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result          (result),
        .carryout        (carryout),
        .overflow        (overflow),
        .zero            (zero),
        .slice_a         (slice_a),
        .slice_b         (slice_b),
        .slice_s         (slice_s),
        .slice_carry_in  (slice_carry_in),
        .slice_k_in      (slice_k_in),
        .slice_ans_in    (slice_ans_in),
        .slice_first     (slice_first),
        .slice_out       (slice_out),
        .slice_carry_out (slice_carry_out),
        .slice_k_out     (slice_k_out),
        .slice_ans_out   (slice_ans_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-bit ALU slice the sequencer is meant to drive.
    always_comb begin
        slice_out       = 1'b0;
        slice_carry_out = 1'b0;
        slice_k_out     = 1'b0;
        slice_ans_out   = 1'b0;
        case (slice_s)
            3'd0, 3'd1: begin
                slice_out       = slice_a ^ slice_b ^ slice_carry_in;
                slice_carry_out = (slice_a & slice_b) | (slice_a & slice_carry_in)
                                | (slice_b & slice_carry_in);
            end
            3'd2: slice_out = slice_a ^ slice_b;
            3'd3: begin
                slice_k_out   = slice_k_in & (slice_a ~^ slice_b);
                slice_ans_out = slice_first ? (slice_a & ~slice_b)
                              : (slice_ans_in | (slice_k_in & ~slice_a & slice_b));
            end
            3'd4: slice_out = slice_a & slice_b;
            3'd5: slice_out = ~(slice_a & slice_b);
            3'd6: slice_out = ~(slice_a | slice_b);
            default: slice_out = slice_a | slice_b;
        endcase
    end

    function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] x,
                                      input logic [W-1:0] y, output logic [W-1:0] r,
                                      output logic co, output logic ov, output logic z);
        logic [W:0] s;
        s  = '0;
        r  = '0;
        co = 1'b0;
        ov = 1'b0;
        case (o)
            3'd0: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                s  = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd2: r = x ^ y;
            3'd3: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            3'd4: r = x & y;
            3'd5: r = ~(x & y);
            3'd6: r = ~(x | y);
            default: r = x | y;
        endcase
        z = (r == '0);
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic co, output logic ov,
                         output logic z, output int lat);
        int guard;
        guard = 0;
        while (!start_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o;
        a = x;
        b = y;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 0;
        first_cnt = 0;
        first_cyc = -1;
        first_a = 1'b0;
        while (!result_valid && lat < 100) begin
            if (slice_first) begin
                first_cnt++;
                first_cyc = lat;
                first_a = slice_a;
            end
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        co = carryout;
        ov = overflow;
        z = zero;
        if (result_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got ready=%b valid=%b exp 1 0", start_ready, result_valid);
        end
        checks++;
        if ({result, carryout, overflow, zero} !== '0) begin
            errors++;
            $display("FAIL reset_out got %h %b%b%b exp 0", result, carryout, overflow, zero);
        end
        checks++;
        if ({slice_a, slice_b, slice_s, slice_carry_in, slice_k_in, slice_ans_in,
             slice_first} !== 9'd0) begin
            errors++;
            $display("FAIL reset_slice got nonzero slice outputs exp 0");
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [W-1:0] r;
        logic co, ov, z;
        int lat;
        do_op(3'd0, 32'h7FFF_FFFF, 32'h1, r, co, ov, z, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL add_latency got=%0d exp=33", lat);
        end
        checks++;
        if ({r, co, ov, z} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ovf got=%h %b%b%b exp=80000000 010", r, co, ov, z);
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] r;
        logic co, ov, z;
        int lat;
        do_op(3'd1, 32'd9, 32'd9, r, co, ov, z, lat);
        checks++;
        if ({r, co, ov, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_equal got=%h %b%b%b exp=00000000 101", r, co, ov, z);
        end
        do_op(3'd1, 32'd5, 32'd7, r, co, ov, z, lat);
        checks++;
        if ({r, co, ov, z} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_neg got=%h %b%b%b exp=fffffffe 000", r, co, ov, z);
        end
    endtask

    task automatic test_slt();
        logic [W-1:0] r;
        logic co, ov, z;
        int lat;
        do_op(3'd3, 32'hFFFF_FFFF, 32'h1, r, co, ov, z, lat);
        checks++;
        if ({r, co, ov, z} !== {32'h1, 3'b000}) begin
            errors++;
            $display("FAIL slt_neg got=%h %b%b%b exp=00000001 000", r, co, ov, z);
        end
        checks++;
        if (first_cnt !== 1 || first_cyc !== 0 || first_a !== 1'b1) begin
            errors++;
            $display("FAIL slt_first got cnt=%0d cyc=%0d a=%b exp 1 0 1",
                     first_cnt, first_cyc, first_a);
        end
        do_op(3'd3, 32'h1, 32'hFFFF_FFFF, r, co, ov, z, lat);
        checks++;
        if ({r, z} !== {32'h0, 1'b1} || first_a !== 1'b0) begin
            errors++;
            $display("FAIL slt_pos got=%h z=%b msb=%b exp=00000000 1 0", r, z, first_a);
        end
        do_op(3'd3, 32'h1234_5678, 32'h1234_5678, r, co, ov, z, lat);
        checks++;
        if ({r, z} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL slt_eq got=%h z=%b exp=00000000 1", r, z);
        end
    endtask

    task automatic test_logic();
        logic [2:0]   ops [5] = '{3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [W-1:0] exps[5] = '{32'h0FF0_0FF0, 32'hF000_F000, 32'h0FFF_0FFF,
                                  32'h000F_000F, 32'hFFF0_FFF0};
        logic [W-1:0] r;
        logic co, ov, z;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], 32'hF0F0_F0F0, 32'hFF00_FF00, r, co, ov, z, lat);
            checks++;
            if ({r, co, ov, z} !== {exps[i], 3'b000} || lat !== 33) begin
                errors++;
                $display("FAIL logic_op%0d got=%h %b%b%b lat=%0d exp=%h 000 lat=33",
                         ops[i], r, co, ov, z, lat, exps[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, y, er, hr;
        logic eco, eov, ez, hco, hov, hz;
        int guard;
        x = $urandom;
        y = $urandom;
        ref_model(3'd0, x, y, er, eco, eov, ez);
        result_ready = 1'b0;
        op = 3'd0;
        a = x;
        b = y;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        guard = 0;
        while (!result_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        hr = result;
        hco = carryout;
        hov = overflow;
        hz = zero;
        checks++;
        if ({hr, hco, hov, hz} !== {er, eco, eov, ez} || guard !== 33) begin
            errors++;
            $display("FAIL bp_result got=%h %b%b%b lat=%0d exp=%h %b%b%b lat=33",
                     hr, hco, hov, hz, guard, er, eco, eov, ez);
        end
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            op = 3'($urandom);
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
            checks++;
            if ({result, carryout, overflow, zero} !== {hr, hco, hov, hz} ||
                result_valid !== 1'b1 || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got=%h v=%b rdy=%b exp=%h v=1 rdy=0",
                         i, result, result_valid, start_ready, hr);
            end
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", result_valid, start_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r;
        logic co, ov, z;
        int lat;
        op = 3'd0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || result_valid !== 1'b0 ||
            {slice_a, slice_b, slice_s, slice_carry_in, slice_k_in, slice_ans_in,
             slice_first} !== 9'd0) begin
            errors++;
            $display("FAIL abort got rdy=%b v=%b s=%0d exp rdy=1 v=0 slices 0",
                     start_ready, result_valid, slice_s);
        end
        do_op(3'd0, 32'd2, 32'd3, r, co, ov, z, lat);
        checks++;
        if ({r, co, ov, z} !== {32'd5, 3'b000}) begin
            errors++;
            $display("FAIL abort_next got=%h %b%b%b exp=00000005 000", r, co, ov, z);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] edge_vals[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [W-1:0] x, y, r, er;
        logic [2:0] o;
        logic co, ov, z, eco, eov, ez;
        int lat;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom);
            x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 7) == 0) y = x;
            ref_model(o, x, y, er, eco, eov, ez);
            do_op(o, x, y, r, co, ov, z, lat);
            checks++;
            if ({r, co, ov, z} !== {er, eco, eov, ez} || lat !== W + 1) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%h %b%b%b lat=%0d exp=%h %b%b%b",
                         i, o, x, y, r, co, ov, z, lat, er, eco, eov, ez);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
